// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: fixed-width words, the decode hand-off
// record, the fetch FSM states and the reset PC.
package fetch_unit_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  localparam u64 PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    REQ,
    DROP,
    OUT
  } fetch_state_t;

  typedef struct packed {
    u64   pc;
    u32   raw_instr;
    logic valid;
  } fetch_data_t;

  // Sequential successor; plain 64-bit add so it wraps at 2^64.
  function automatic u64 next_seq_pc(input u64 pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-bus, pipeline-control and decode hand-off signals of the fetch stage.
// The master side is the fetch unit; the slave side is bus, decode and redirect logic.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic        ireq_valid;
  u64          ireq_addr;
  logic        iresp_data_ok;
  u32          iresp_data;
  logic        stall;
  logic        redirect;
  u64          redirect_pc;
  fetch_data_t dataF_nxt;

  modport master (
    output ireq_valid, ireq_addr, dataF_nxt,
    input  iresp_data_ok, iresp_data, stall, redirect, redirect_pc
  );

  modport slave (
    input  ireq_valid, ireq_addr, dataF_nxt,
    output iresp_data_ok, iresp_data, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_perf_counter.sv
// Fetch performance counters (FETCH_PERF_CNT_EN builds only); 1-cycle update latency.
// No backpressure: each counter increments on its strobe and wraps at 2^64.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_counter
  import fetch_unit_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic fetched_inc,
  input  logic bus_wait_inc,
  output u64   perf_fetched,
  output u64   perf_bus_wait
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched  <= '0;
      perf_bus_wait <= '0;
    end else begin
      if (fetched_inc)  perf_fetched  <= perf_fetched + 64'd1;
      if (bus_wait_inc) perf_bus_wait <= perf_bus_wait + 64'd1;
    end
  end

endmodule
`endif

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch; output valid the cycle after data_ok (>=2 cycles/instr).
// stall holds the presented instruction; redirect flushes. FETCH_PERF_CNT_EN adds perf counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter u64 PC_RESET = PC_RESET_DEFAULT
)
(
  input  logic           clk,
  input  logic           reset,
  fetch_unit_if.master   bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output u64             perf_fetched,
  output u64             perf_bus_wait
`endif
);

  fetch_state_t state, state_nxt;
  u64           pc, pc_nxt;
  u64           pend_pc, pend_pc_nxt;
  u32           instr_q, instr_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= REQ;
      pc      <= PC_RESET;
      pend_pc <= '0;
      instr_q <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pend_pc <= pend_pc_nxt;
      instr_q <= instr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pend_pc_nxt = pend_pc;
    instr_nxt   = instr_q;
    case (state)
      REQ: begin
        if (bus.iresp_data_ok && !bus.redirect) begin
          instr_nxt = bus.iresp_data;
          state_nxt = OUT;
        end else if (bus.redirect && !bus.iresp_data_ok) begin
          // The issued request must complete before the new target can be sent.
          pend_pc_nxt = bus.redirect_pc;
          state_nxt   = DROP;
        end else if (bus.redirect && bus.iresp_data_ok) begin
          pc_nxt = bus.redirect_pc;
        end
      end
      DROP: begin
        if (bus.redirect) pend_pc_nxt = bus.redirect_pc;
        if (bus.iresp_data_ok) begin
          pc_nxt    = bus.redirect ? bus.redirect_pc : pend_pc;
          state_nxt = REQ;
        end
      end
      OUT: begin
        if (bus.redirect) begin
          pc_nxt    = bus.redirect_pc;
          state_nxt = REQ;
        end else if (!bus.stall) begin
          pc_nxt    = next_seq_pc(pc);
          state_nxt = REQ;
        end
      end
      default: state_nxt = REQ;
    endcase
  end

  always_comb begin
    bus.ireq_valid = 1'b0;
    bus.ireq_addr  = pc;
    bus.dataF_nxt  = '0;
    if (state != OUT && !reset) bus.ireq_valid = 1'b1;
    if (state == OUT) begin
      bus.dataF_nxt.pc        = pc;
      bus.dataF_nxt.raw_instr = instr_q;
      bus.dataF_nxt.valid     = !bus.redirect;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counter u_perf (
    .clk           (clk),
    .reset         (reset),
    .fetched_inc   (state == OUT && !bus.stall && !bus.redirect),
    .bus_wait_inc  (state != OUT && !bus.iresp_data_ok),
    .perf_fetched  (perf_fetched),
    .perf_bus_wait (perf_bus_wait)
  );
`endif

  // A response can only belong to an outstanding request.
  a_no_resp_in_out: assert property (@(posedge clk) disable iff (reset)
    !(state == OUT && bus.iresp_data_ok));

endmodule
